// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central hazard controller for the five-stage MIPS pipeline.
//
// Purpose:
//   Drives enables/flushes for PC and the IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers. Handles data-memory freezes, taken-branch flushes and load-use
//   stalls (in that priority), and registers the forwarding selects that ride
//   into EX with each instruction.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt   source fields of the instruction in ID
//   ex_dest, ex_reg_write,
//   ex_mem_read                destination info of the instruction in EX
//   mem_dest, mem_reg_write    destination info of the instruction in MEM
//   branch_taken               branch resolved taken in EX (held while frozen)
//   dmem_wait                  data memory not ready this cycle
//   pc_en .. memwb_en          register enables (combinational)
//   ifid_flush, idex_flush     bubble inserts (combinational)
//   fwd_a, fwd_b               registered forwarding selects:
//                              00 regfile, 01 MEM/WB, 10 EX/MEM
//   state                      00 RUN, 01 LSTALL, 10 FREEZE (previous cycle)
//   timeout_err                sticky freeze-timeout flag
//   stat_stall/flush/freeze    saturating event counters (HAZ_STATS_EN only)
//
// Optional feature macro: HAZ_STATS_EN adds the statistics counters.

module pipe_hazard_ctrl #(
  parameter int REG_AW         = 5,
  parameter int FREEZE_TIMEOUT = 64,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_reg_write,
  input  logic              branch_taken,
  input  logic              dmem_wait,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        state,
`ifdef HAZ_STATS_EN
  output logic [CNT_W-1:0]  stat_stall,
  output logic [CNT_W-1:0]  stat_flush,
  output logic [CNT_W-1:0]  stat_freeze,
`endif
  output logic              timeout_err
);

  typedef enum logic [1:0] {RUN = 2'b00, LSTALL = 2'b01, FREEZE = 2'b10} state_e;

  localparam int FCW = $clog2(FREEZE_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic             terr_q;
  logic             freeze_c, flush_c, lu_hit, stall_c;

  // Forwarding select for one source operand; EX/MEM match beats MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (ex_reg_write && ex_dest != '0 && ex_dest == src)        return 2'b10;
    else if (mem_reg_write && mem_dest != '0 && mem_dest == src) return 2'b01;
    else                                                         return 2'b00;
  endfunction

  always_comb begin
    freeze_c = dmem_wait;
    flush_c  = !dmem_wait && branch_taken;
    lu_hit   = ex_mem_read && ex_dest != '0 &&
               (ex_dest == id_rs || (id_uses_rt && ex_dest == id_rt));
    stall_c  = !freeze_c && !flush_c && lu_hit;
  end

  // Control outputs. Reset holds every register and bubbles IF/ID and ID/EX.
  always_comb begin
    pc_en = 1'b1; ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1; memwb_en = 1'b1;
    ifid_flush = 1'b0; idex_flush = 1'b0;
    if (reset) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      ifid_flush = 1'b1; idex_flush = 1'b1;
    end else if (freeze_c) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
    end else if (flush_c) begin
      ifid_flush = 1'b1; idex_flush = 1'b1;
    end else if (stall_c) begin
      pc_en = 1'b0; ifid_en = 1'b0; idex_flush = 1'b1;
    end
  end

  always_comb begin
    if (freeze_c)     state_d = FREEZE;
    else if (stall_c) state_d = LSTALL;
    else              state_d = RUN;

    // Selects follow ID/EX: cleared by a bubble, held while ID/EX is held.
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (idex_flush) begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
    end else if (idex_en) begin
      fwd_a_d = fwd_sel(id_rs);
      fwd_b_d = id_uses_rt ? fwd_sel(id_rt) : 2'b00;
    end

    fcnt_d = '0;
    if (freeze_c)
      fcnt_d = (fcnt_q == FCW'(FREEZE_TIMEOUT)) ? fcnt_q : fcnt_q + FCW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
      fcnt_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      fcnt_q  <= fcnt_d;
      if (fcnt_d == FCW'(FREEZE_TIMEOUT)) terr_q <= 1'b1;
    end
  end

  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign state       = state_q;
  assign timeout_err = terr_q;

`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] st_stall_q, st_flush_q, st_freeze_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_stall_q  <= '0;
      st_flush_q  <= '0;
      st_freeze_q <= '0;
    end else begin
      if (stall_c  && st_stall_q  != '1) st_stall_q  <= st_stall_q  + CNT_W'(1);
      if (flush_c  && st_flush_q  != '1) st_flush_q  <= st_flush_q  + CNT_W'(1);
      if (freeze_c && st_freeze_q != '1) st_freeze_q <= st_freeze_q + CNT_W'(1);
    end
  end

  assign stat_stall  = st_stall_q;
  assign stat_flush  = st_flush_q;
  assign stat_freeze = st_freeze_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard controller for the five-stage MIPS pipeline.
- Drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards, taken branches and data-memory wait states.
- Produces registered 2-bit forwarding selects that travel with each instruction into EX.

Parameters:
- REG_AW, 5, register-file address width.
- FREEZE_TIMEOUT, 64, consecutive FREEZE cycles before timeout_err sets.
- CNT_W, 16, width of the optional statistics counters.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- id_rs  in  REG_AW  rs field of the instruction in ID
- id_rt  in  REG_AW  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_dest  in  REG_AW  destination register of the instruction in EX
- ex_reg_write  in  1  EX instruction writes the register file
- ex_mem_read  in  1  EX instruction is a load
- mem_dest  in  REG_AW  destination register of the instruction in MEM
- mem_reg_write  in  1  MEM instruction writes the register file
- branch_taken  in  1  branch resolved taken in EX; held while frozen
- dmem_wait  in  1  data memory not ready this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
- ifid_flush, idex_flush  out  1 each  load a bubble (synchronous clear) into IF/ID or ID/EX
- fwd_a, fwd_b  out  2 each  registered forwarding selects for EX: 00 = register file, 01 = MEM/WB, 10 = EX/MEM
- state  out  2  00 RUN, 01 LSTALL, 10 FREEZE
- timeout_err  out  1  sticky freeze-timeout flag

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high.
- Reset cycle, outputs:
  - all enables 0
  - ifid_flush = 1, idex_flush = 1
  - fwd_a = fwd_b = 00, state = RUN (00), timeout_err = 0
- Reset cycle, internal: freeze counter and statistics cleared.
- Control outputs are combinational from the current inputs and state. fwd_a/fwd_b, state, the counters and timeout_err are registered.
- Condition priority, evaluated every cycle (first match wins):
  1. freeze: dmem_wait = 1 -> every enable 0, both flushes 0.
  2. flush: branch_taken = 1 -> all enables 1, ifid_flush = 1, idex_flush = 1.
  3. load-use stall: ex_mem_read = 1 and ex_dest != 0 and (ex_dest == id_rs, or (id_uses_rt = 1 and ex_dest == id_rt)) -> pc_en = 0, ifid_en = 0, idex_flush = 1; idex_en, exmem_en, memwb_en = 1.
  4. run: all enables 1, both flushes 0.
- Next state: FREEZE if condition 1, LSTALL if condition 3, otherwise RUN. state shows the condition applied in the previous cycle.
- Forwarding, fwd_a (source id_rs):
  - select 10 if ex_reg_write = 1, ex_dest != 0 and ex_dest == id_rs;
  - else 01 if mem_reg_write = 1, mem_dest != 0 and mem_dest == id_rs;
  - else 00.
  - The EX match wins over the MEM match.
- Forwarding, fwd_b: same rules on id_rt, evaluated only when id_uses_rt = 1; otherwise 00.
- fwd register update:
  - loaded on a clock edge with idex_en = 1 and idex_flush = 0;
  - cleared to 00 when idex_flush = 1;
  - held when idex_en = 0.
- Load-use sequence: a 1-cycle bubble. On the next cycle the load is in MEM, the stall condition is gone, and the consumer receives select 01.
- Branch during a freeze: no flush while dmem_wait = 1. The flush takes effect on the first cycle with dmem_wait = 0, provided branch_taken is still asserted.
- Freeze counter:
  - increments each FREEZE cycle; clears on any non-freeze cycle;
  - saturates at FREEZE_TIMEOUT;
  - reaching FREEZE_TIMEOUT sets timeout_err, which clears only on reset.
- Reset asserted mid-freeze or mid-stall: the next state is RUN with the reset values above.

Optional Feature:
- Macro: HAZ_STATS_EN.
- Defined:
  - adds outputs stat_stall, stat_flush, stat_freeze (CNT_W each);
  - counts load-use stall cycles, flush events and freeze cycles respectively;
  - each counter saturates at all-ones and clears on reset.
- Undefined: the outputs and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then `add $3,$1,$2` in EX and `sub $4,$3,$5` in ID (ex_reg_write = 1, ex_dest = 3, id_rs = 3) -> all enables 1; after the edge, fwd_a = 10, fwd_b = 00.
- `lw $8` in EX with `add $9,$1,$8` in ID (id_uses_rt = 1) -> pc_en = 0, ifid_en = 0, idex_flush = 1, fwd regs cleared to 00. Next cycle: state = LSTALL, no stall; after that edge fwd_b = 01.
- Destination $0 matching id_rs = 0 with ex_mem_read = 1 -> no stall, fwd_a = 00.
- branch_taken = 1 together with a load-use match -> flushes win: ifid_flush = idex_flush = 1, pc_en = 1.
- dmem_wait high for 3 cycles while branch_taken = 1 -> all enables 0 and no flush for 3 cycles, state = FREEZE; 4th cycle: flushes asserted.
- dmem_wait held 64 cycles -> timeout_err rises after the 64th FREEZE cycle and stays 1 after dmem_wait drops; reset clears it.
